// File: rtl/timer_entry_loader.sv
// MM:SS entry controller: collects keypad digits, loads them into the BCD
// down-counter chain, paces the count enable and halts the countdown at 00:00.
module timer_entry_loader #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic       clock,
  input  logic       clearn,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       start,
  input  logic       stop,
  input  logic       zero,
  output logic [3:0] d_min_tens,
  output logic [3:0] d_min_ones,
  output logic [3:0] d_sec_tens,
  output logic [3:0] d_sec_ones,
  output logic       loadn,
  output logic       en,
  output logic       running,
  output logic       done,
  output logic       err
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_mt, r_mo, r_st, r_so;
  logic [2:0]    r_nkeys;
  logic [TW-1:0] r_tick;
  logic          r_running, r_done, r_err;

  logic w_shift, w_clear, w_reject, w_all_zero, w_key_ok, w_tick_last;

  assign w_all_zero  = (r_mt == 4'd0) && (r_mo == 4'd0) && (r_st == 4'd0) && (r_so == 4'd0);
  assign w_key_ok    = key_valid && (key_code <= 4'd9) && (r_nkeys < 3'd4);
  assign w_tick_last = (r_tick == TICK_LAST);

  // Priority stop > zero > start > key_valid; in IDLE a stop masks start/key.
  always_comb begin
    w_next   = r_state;
    w_shift  = 1'b0;
    w_clear  = 1'b0;
    w_reject = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (stop) begin
          w_next = S_IDLE;
        end else if (start) begin
          if (!w_all_zero) begin
            if (r_st > 4'd5) begin
              w_reject = 1'b1;
              w_clear  = 1'b1;
            end else begin
              w_next = S_LOAD;
            end
          end
        end else if (w_key_ok) begin
          w_shift = 1'b1;
        end
      end
      S_LOAD: w_next = S_RUN;
      S_RUN: begin
        if (stop) begin
          w_next = S_PAUSE;
        end else if (zero) begin
          w_next = S_DONE;
        end
      end
      S_PAUSE: begin
        if (stop) begin
          w_next  = S_IDLE;
          w_clear = 1'b1;
        end else if (start) begin
          w_next = S_RUN;
        end
      end
      S_DONE: begin
        if (start || stop || key_valid) begin
          w_next  = S_IDLE;
          w_clear = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clearn) begin
      r_state   <= S_IDLE;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_running <= (w_next == S_RUN);
      r_done    <= (w_next == S_DONE);
      r_err     <= w_reject;
    end
  end

  always_ff @(posedge clock) begin
    if (!clearn || w_clear) begin
      r_mt    <= '0;
      r_mo    <= '0;
      r_st    <= '0;
      r_so    <= '0;
      r_nkeys <= '0;
    end else if (w_shift) begin
      r_mt    <= r_mo;
      r_mo    <= r_st;
      r_st    <= r_so;
      r_so    <= key_code;
      r_nkeys <= r_nkeys + 3'd1;
    end
  end

  // Tick holds while stopping so a resumed run finishes the partial period.
  always_ff @(posedge clock) begin
    if (!clearn || (r_state == S_LOAD)) begin
      r_tick <= '0;
    end else if ((r_state == S_RUN) && !stop && !zero) begin
      r_tick <= w_tick_last ? '0 : r_tick + TW'(1);
    end
  end

  assign d_min_tens = r_mt;
  assign d_min_ones = r_mo;
  assign d_sec_tens = r_st;
  assign d_sec_ones = r_so;
  assign loadn      = (r_state != S_LOAD);
  assign en         = (r_state == S_RUN) && w_tick_last && !zero && !stop;
  assign running    = r_running;
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_timer_entry_loader.sv
// Bench for timer_entry_loader: drives a BCD down-counter chain model and
// checks entry, load, pacing, pause, priority and reset behaviour.
module tb_timer_entry_loader;

  localparam int unsigned TD = 4;

  logic       clock = 1'b0;
  logic       clearn, key_valid, start, stop, zero;
  logic [3:0] key_code;
  logic [3:0] d_mt, d_mo, d_st, d_so;
  logic       loadn, en, running, done, err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [15:0] m_cnt  = 16'h0000;
  logic        zforce = 1'b0;

  logic [15:0] exp_dig_q[$];
  int          exp_en_q[$];

  always #5 clock = ~clock;

  timer_entry_loader #(.TICK_DIV(TD)) dut (
    .clock(clock), .clearn(clearn), .key_valid(key_valid), .key_code(key_code),
    .start(start), .stop(stop), .zero(zero),
    .d_min_tens(d_mt), .d_min_ones(d_mo), .d_sec_tens(d_st), .d_sec_ones(d_so),
    .loadn(loadn), .en(en), .running(running), .done(done), .err(err)
  );

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = v;
    if (so != 0) so = so - 1;
    else begin
      so = 9;
      if (st != 0) st = st - 1;
      else begin
        st = 5;
        if (mo != 0) mo = mo - 1;
        else begin
          mo = 9;
          mt = (mt != 0) ? mt - 1 : 4'd9;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  always @(posedge clock) begin
    if (loadn === 1'b0) m_cnt <= {d_mt, d_mo, d_st, d_so};
    else if (en === 1'b1) m_cnt <= bcd_dec(m_cnt);
  end

  assign zero = (m_cnt == 16'h0000) || zforce;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    step();
    key_valid = 1'b0;
  endtask

  task automatic enter(input logic [15:0] t);
    press(t[15:12]);
    press(t[11:8]);
    press(t[7:4]);
    press(t[3:0]);
  endtask

  task automatic do_reset();
    clearn = 1'b0;
    step();
    step();
    clearn = 1'b1;
    step();
  endtask

  // Start pulse; returns the edge index at which RUN is entered.
  task automatic start_run(output int e, output int lows);
    lows  = 0;
    start = 1'b1;
    @(negedge clock);
    if (!loadn) lows++;
    step();
    start = 1'b0;
    @(negedge clock);
    if (!loadn) lows++;
    step();
    @(negedge clock);
    if (!loadn) lows++;
    e = cyc;
    checks++;
    if (running !== 1'b1) begin
      errors++;
      $display("FAIL run_entry: running=%b expected 1", running);
    end
  endtask

  task automatic test_reset();
    clearn = 1'b0;
    step();
    step();
    @(negedge clock);
    checks++;
    if ({d_mt, d_mo, d_st, d_so, loadn, en, running, done, err} !== {16'h0000, 1'b1, 4'b0000}) begin
      errors++;
      $display("FAIL reset_state: got %h %b%b%b%b%b expected 0000 10000",
               {d_mt, d_mo, d_st, d_so}, loadn, en, running, done, err);
    end
    clearn = 1'b1;
    step();
  endtask

  task automatic test_entry();
    logic [3:0]  codes[6];
    logic [15:0] exps[6];
    logic [15:0] e;
    codes = '{4'd11, 4'd1, 4'd2, 4'd3, 4'd0, 4'd9};
    exps  = '{16'h0000, 16'h0001, 16'h0012, 16'h0123, 16'h1230, 16'h1230};
    for (int i = 0; i < 6; i++) begin
      exp_dig_q.push_back(exps[i]);
      press(codes[i]);
      @(negedge clock);
      e = exp_dig_q.pop_front();
      checks++;
      if ({d_mt, d_mo, d_st, d_so} !== e) begin
        errors++;
        $display("FAIL entry_key%0d: digits %h expected %h", i, {d_mt, d_mo, d_st, d_so}, e);
      end
    end
  endtask

  task automatic test_load_run();
    int e, lows, done_cyc, got, bad;
    do_reset();
    enter(16'h0003);
    start_run(e, lows);
    checks++;
    if (lows != 1) begin
      errors++;
      $display("FAIL loadn_width: low cycles %0d expected 1", lows);
    end
    exp_en_q.push_back(e + 4);
    exp_en_q.push_back(e + 8);
    exp_en_q.push_back(e + 12);
    done_cyc = -1;
    for (int i = 0; i < 30; i++) begin
      step();
      @(negedge clock);
      if (en && zero) begin
        checks++;
        errors++;
        $display("FAIL en_with_zero: en=1 zero=1 at edge %0d expected en=0", cyc);
      end
      if (en) begin
        checks++;
        if (exp_en_q.size() == 0) begin
          errors++;
          $display("FAIL en_extra: en at capture edge %0d expected none", cyc + 1);
        end else begin
          got = exp_en_q.pop_front();
          if (cyc + 1 != got) begin
            errors++;
            $display("FAIL en_timing: capture edge %0d expected %0d", cyc + 1, got);
          end
        end
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    checks++;
    if (done_cyc != e + 13) begin
      errors++;
      $display("FAIL done_edge: got %0d expected %0d", done_cyc, e + 13);
    end
    checks++;
    if (exp_en_q.size() != 0) begin
      errors++;
      $display("FAIL en_missing: %0d pulses outstanding expected 0", exp_en_q.size());
      exp_en_q.delete();
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clock);
      if (en || !done || running) bad++;
    end
    checks++;
    if (bad != 0 || m_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL done_hold: bad cycles %0d count %h expected 0 and 0000", bad, m_cnt);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    @(negedge clock);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_exit: done=%b expected 0", done);
    end
  endtask

  task automatic test_invalid();
    int lows, errs;
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    @(negedge clock);
    checks++;
    if (loadn !== 1'b1 || running !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL start_all_zero: loadn=%b running=%b err=%b expected 1 0 0", loadn, running, err);
    end
    enter(16'h0070);
    lows = 0;
    errs = 0;
    start = 1'b1;
    @(negedge clock);
    if (!loadn) lows++;
    step();
    start = 1'b0;
    @(negedge clock);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_pulse: err=%b expected 1", err);
    end
    for (int i = 0; i < 4; i++) begin
      if (!loadn) lows++;
      if (err) errs++;
      step();
      @(negedge clock);
    end
    checks++;
    if (lows != 0 || errs != 1 || running !== 1'b0) begin
      errors++;
      $display("FAIL err_side: loadn lows %0d err cycles %0d running %b expected 0 1 0", lows, errs, running);
    end
    exp_dig_q.push_back(16'h0005);
    press(4'd5);
    @(negedge clock);
    checks++;
    if ({d_mt, d_mo, d_st, d_so} !== exp_dig_q[0]) begin
      errors++;
      $display("FAIL err_cleared: digits %h expected %h", {d_mt, d_mo, d_st, d_so}, exp_dig_q[0]);
    end
    void'(exp_dig_q.pop_front());
  endtask

  task automatic test_pause_and_simul();
    int e, lows, bad, r, got;
    do_reset();
    enter(16'h0009);
    start_run(e, lows);
    step();
    step();
    stop = 1'b1;
    @(negedge clock);
    checks++;
    if (en !== 1'b0) begin
      errors++;
      $display("FAIL pause_en: en=%b expected 0", en);
    end
    step();
    stop = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (en || running) bad++;
      step();
    end
    checks++;
    if (bad != 0 || {d_mt, d_mo, d_st, d_so} !== 16'h0009) begin
      errors++;
      $display("FAIL pause_hold: bad cycles %0d digits %h expected 0 0009", bad, {d_mt, d_mo, d_st, d_so});
    end
    start = 1'b1;
    step();
    start = 1'b0;
    r = cyc;
    exp_en_q.push_back(r + 2);
    @(negedge clock);
    checks++;
    if (running !== 1'b1 || en !== 1'b0) begin
      errors++;
      $display("FAIL resume: running=%b en=%b expected 1 0", running, en);
    end
    step();
    @(negedge clock);
    got = exp_en_q.pop_front();
    checks++;
    if (en !== 1'b1 || cyc + 1 != got) begin
      errors++;
      $display("FAIL resume_en: en=%b capture %0d expected 1 at %0d", en, cyc + 1, got);
    end
    step();
    stop  = 1'b1;
    start = 1'b1;
    @(negedge clock);
    checks++;
    if (en !== 1'b0) begin
      errors++;
      $display("FAIL simul_en: en=%b expected 0", en);
    end
    step();
    @(negedge clock);
    checks++;
    if (running !== 1'b0 || {d_mt, d_mo, d_st, d_so} !== 16'h0009) begin
      errors++;
      $display("FAIL simul_run: running=%b digits %h expected 0 0009", running, {d_mt, d_mo, d_st, d_so});
    end
    step();
    stop  = 1'b0;
    start = 1'b0;
    @(negedge clock);
    checks++;
    if ({d_mt, d_mo, d_st, d_so} !== 16'h0000 || running || done) begin
      errors++;
      $display("FAIL simul_pause: digits %h running %b done %b expected 0000 0 0",
               {d_mt, d_mo, d_st, d_so}, running, done);
    end
  endtask

  task automatic test_zero_tick();
    int e, lows;
    do_reset();
    enter(16'h0009);
    start_run(e, lows);
    step();
    step();
    step();
    zforce = 1'b1;
    @(negedge clock);
    checks++;
    if (en !== 1'b0) begin
      errors++;
      $display("FAIL zero_tick_en: en=%b expected 0", en);
    end
    step();
    @(negedge clock);
    checks++;
    if (done !== 1'b1 || running !== 1'b0 || m_cnt !== 16'h0009) begin
      errors++;
      $display("FAIL zero_tick_done: done=%b running=%b count %h expected 1 0 0009", done, running, m_cnt);
    end
    zforce = 1'b0;
    stop   = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_reset_midrun();
    int e, lows;
    do_reset();
    enter(16'h0005);
    start_run(e, lows);
    step();
    step();
    @(negedge clock);
    checks++;
    if (running !== 1'b1) begin
      errors++;
      $display("FAIL midrun_pre: running=%b expected 1", running);
    end
    clearn = 1'b0;
    step();
    @(negedge clock);
    checks++;
    if ({d_mt, d_mo, d_st, d_so, loadn, en, running} !== {16'h0000, 1'b1, 2'b00}) begin
      errors++;
      $display("FAIL midrun_reset: digits %h loadn %b en %b running %b expected 0000 1 0 0",
               {d_mt, d_mo, d_st, d_so}, loadn, en, running);
    end
    clearn = 1'b1;
    step();
  endtask

  initial begin
    clearn    = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'd0;
    start     = 1'b0;
    stop      = 1'b0;
    test_reset();
    test_entry();
    test_load_run();
    test_invalid();
    test_pause_and_simul();
    test_zero_tick();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
